// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types, constants and helpers for the iterative
// signed multiplier/divider. The divider datapath is present only when
// MULTDIV_DIV_EN is defined.
package multdiv_pkg;

  localparam int          MD_WIDTH   = 32;
  localparam int          MD_ITER    = 32;
  localparam logic [31:0] MD_INT_MIN = 32'h80000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  // Absolute value of a two's complement word; INT_MIN maps to 0x80000000
  // which is its correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  // A 64-bit signed product fits in 32 bits only when bits 63..31 agree.
  function automatic logic mul_overflow(input logic [63:0] p);
    return !((p[63:31] == {33{1'b0}}) || (p[63:31] == {33{1'b1}}));
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one combinational iteration of the shift-add multiplier or
// the restoring divider. acc holds {upper, lower} for multiply and
// {remainder, quotient} for divide. Divider logic needs MULTDIV_DIV_EN.
module multdiv_step
  import multdiv_pkg::*;
(
  input  logic        div_mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] sum_s;
  logic [63:0] mul_next_s;
`ifdef MULTDIV_DIV_EN
  logic [63:0] shifted_s;
  logic [32:0] diff_s;
  logic [63:0] div_next_s;
`endif

  // Multiply: conditionally add the multiplicand to the upper half, then
  // shift the whole 65-bit result right by one (carry enters bit 63).
  always_comb begin
    sum_s      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    mul_next_s = {sum_s, acc[31:1]};
  end

`ifdef MULTDIV_DIV_EN
  // Divide: shift {rem,quo} left, trial-subtract, keep if non-negative.
  always_comb begin
    shifted_s = {acc[62:0], 1'b0};
    diff_s    = {1'b0, shifted_s[63:32]} - {1'b0, operand};
    if (diff_s[32]) begin
      div_next_s = shifted_s;
    end else begin
      div_next_s = {diff_s[31:0], shifted_s[31:1], 1'b1};
    end
  end

  // Select the iteration matching the current operation.
  always_comb begin
    acc_next = div_mode ? div_next_s : mul_next_s;
  end
`else
  // Without a divider a divide sequence only counts; the accumulator is
  // cleared because the final result is fixed.
  always_comb begin
    acc_next = div_mode ? 64'd0 : mul_next_s;
  end
`endif

endmodule

// File: rtl/multdiv.sv
// multdiv: iterative 32-bit signed multiply/divide with a fixed 33-cycle
// latency and a one-cycle ready strobe. Define MULTDIV_DIV_EN to include
// the restoring divider; otherwise divides finish with result 0, exception 1.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [4:0] LAST_CNT = 5'(MD_ITER - 1);

  md_state_e   state_r;
  md_state_e   state_next_s;
  logic [4:0]  cnt_r;
  logic [63:0] acc_r;
  logic [63:0] acc_step_s;
  logic [31:0] op_r;
  logic        sign_r;
  logic        is_div_r;
`ifdef MULTDIV_DIV_EN
  logic        div_zero_r;
`endif
  logic        start_mult_s;
  logic        start_div_s;
  logic        start_s;
  logic [63:0] prod_s;
  logic [31:0] fix_result_s;
  logic        fix_exc_s;
  logic [31:0] result_next_s;
  logic        exc_next_s;
  logic        rdy_next_s;
  logic        busy_next_s;

  // Simultaneous start requests are contradictory and are ignored.
  assign start_mult_s = ctrl_MULT & ~ctrl_DIV;
  assign start_div_s  = ctrl_DIV & ~ctrl_MULT;
  assign start_s      = start_mult_s | start_div_s;

  multdiv_step u_step (
    .div_mode (is_div_r),
    .acc      (acc_r),
    .operand  (op_r),
    .acc_next (acc_step_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: a valid start always wins and restarts the sequence.
  always_comb begin
    state_next_s = state_r;
    if (start_mult_s) begin
      state_next_s = MULT;
    end else if (start_div_s) begin
`ifdef MULTDIV_DIV_EN
      state_next_s = DIV;
`else
      state_next_s = MULT;
`endif
    end else begin
      case (state_r)
        IDLE:      state_next_s = IDLE;
        MULT, DIV: state_next_s = (cnt_r == LAST_CNT) ? FIX : state_r;
        FIX:       state_next_s = IDLE;
        default:   state_next_s = IDLE;
      endcase
    end
  end

  // Operand capture at start, then one iteration per cycle in MULT/DIV.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r      <= 5'd0;
      acc_r      <= 64'd0;
      op_r       <= 32'd0;
      sign_r     <= 1'b0;
      is_div_r   <= 1'b0;
`ifdef MULTDIV_DIV_EN
      div_zero_r <= 1'b0;
`endif
    end else if (start_s) begin
      cnt_r      <= 5'd0;
      sign_r     <= data_operandA[31] ^ data_operandB[31];
      is_div_r   <= start_div_s;
      op_r       <= start_div_s ? magnitude(data_operandB) : magnitude(data_operandA);
      acc_r      <= {32'd0, start_div_s ? magnitude(data_operandA) : magnitude(data_operandB)};
`ifdef MULTDIV_DIV_EN
      div_zero_r <= (data_operandB == 32'd0);
`endif
    end else if ((state_r == MULT) || (state_r == DIV)) begin
      cnt_r <= cnt_r + 5'd1;
      acc_r <= acc_step_s;
    end
  end

  // Sign fix-up and exception detection applied in the FIX cycle.
  always_comb begin
    prod_s       = sign_r ? (64'd0 - acc_r) : acc_r;
    fix_result_s = prod_s[31:0];
    fix_exc_s    = mul_overflow(prod_s);
    if (is_div_r) begin
`ifdef MULTDIV_DIV_EN
      if (div_zero_r) begin
        fix_result_s = 32'd0;
        fix_exc_s    = 1'b1;
      end else begin
        // A positive quotient of magnitude 2^31 only arises from INT_MIN / -1.
        fix_result_s = sign_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        fix_exc_s    = ~sign_r & (acc_r[31:0] == MD_INT_MIN);
      end
`else
      fix_result_s = 32'd0;
      fix_exc_s    = 1'b1;
`endif
    end else begin
      fix_result_s = prod_s[31:0];
      fix_exc_s    = mul_overflow(prod_s);
    end
  end

  // Output next values: result updates only on a FIX that is not abandoned.
  always_comb begin
    rdy_next_s    = (state_r == FIX) && !start_s;
    result_next_s = rdy_next_s ? fix_result_s : data_result;
    exc_next_s    = rdy_next_s ? fix_exc_s : data_exception;
    busy_next_s   = (state_next_s != IDLE) || rdy_next_s;
  end

  // Registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_result    <= result_next_s;
      data_exception <= exc_next_s;
      data_resultRDY <= rdy_next_s;
      busy           <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: scoreboard bench for multdiv. Expected results come from a
// signed reference computed with 64-bit integer arithmetic.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic is_div, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!is_div) begin
      p     = sx * sy;
      e.res = p[31:0];
      e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else begin
`ifdef MULTDIV_DIV_EN
      if (y == 32'd0) begin
        e.res = 32'd0;
        e.exc = 1'b1;
      end else if ((x == 32'h80000000) && (y == 32'hFFFFFFFF)) begin
        e.res = 32'h80000000;
        e.exc = 1'b1;
      end else begin
        p     = sx / sy;
        e.res = p[31:0];
        e.exc = 1'b0;
      end
`else
      e.res = 32'd0;
      e.exc = 1'b1;
`endif
    end
    return e;
  endfunction

  // Pulse a start at the next edge (E0); returns at the falling edge after E0.
  task automatic start_op(input logic is_div, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_after_start: got %b want 1", busy);
      n_bad++;
    end
  endtask

  // Wait for RDY, check latency and pop/compare the scoreboard entry.
  task automatic wait_result(input string name);
    int   cycles;
    exp_t e;
    cycles = 0;
    while ((data_resultRDY !== 1'b1) && (cycles < 40)) begin
      @(negedge clock);
      cycles++;
    end
    n_vec++;
    if (cycles != 33) begin
      $display("FAIL %s latency: got %0d cycles want 33", name, cycles);
      n_bad++;
    end
    if (sb.size() == 0) begin
      n_vec++;
      $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
      n_bad++;
    end else begin
      e = sb.pop_front();
      n_vec++;
      if ((data_result !== e.res) || (data_exception !== e.exc)) begin
        $display("FAIL %s result: got %h/%b want %h/%b", name, data_result, data_exception, e.res, e.exc);
        n_bad++;
      end
    end
    @(negedge clock);
    n_vec++;
    if ((data_resultRDY !== 1'b0) || (busy !== 1'b0)) begin
      $display("FAIL %s strobe_end: got rdy=%b busy=%b want 0/0", name, data_resultRDY, busy);
      n_bad++;
    end
  endtask

  task automatic run_op(input logic is_div, input logic [31:0] x, input logic [31:0] y, input string name);
    sb.push_back(model(is_div, x, y));
    start_op(is_div, x, y);
    wait_result(name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if ((data_result !== 32'd0) || (data_exception !== 1'b0) || (data_resultRDY !== 1'b0) || (busy !== 1'b0)) begin
      $display("FAIL reset_state: got %h/%b/%b/%b want 0/0/0/0", data_result, data_exception, data_resultRDY, busy);
      n_bad++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    run_op(1'b0, 32'd7, 32'hFFFFFFFA, "mul_7x-6");
    run_op(1'b0, 32'h00010000, 32'h00010000, "mul_ovf");
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul_-1x-1");
    run_op(1'b0, 32'h80000000, 32'd1, "mul_min_x1");
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, "mul_min_x-1");
    run_op(1'b0, 32'd0, 32'h12345678, "mul_zero");
  endtask

  task automatic test_div();
    run_op(1'b1, 32'hFFFFFFD5, 32'd5, "div_-43/5");
    run_op(1'b1, 32'd10, 32'd0, "div_by_zero");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_min/-1");
    run_op(1'b1, 32'd100, 32'd4, "div_100/4");
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, "div_7/-2");
    run_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, "div_-7/-2");
    run_op(1'b1, 32'h80000000, 32'd1, "div_min/1");
    run_op(1'b1, 32'd3, 32'd7, "div_small");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(1'(i % 2), $urandom, (i == 6) ? 32'($urandom_range(1, 300)) : $urandom, "random");
    end
  endtask

  // Restart at E10 abandons the first operation; only the second completes.
  task automatic test_back_to_back();
    int early;
    early = 0;
    start_op(1'b0, 32'd3, 32'd3);
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) early++;
    end
    sb.push_back(model(1'b1, 32'd100, 32'd4));
    start_op(1'b1, 32'd100, 32'd4);
    n_vec++;
    if (early != 0) begin
      $display("FAIL restart_early_rdy: got %0d want 0", early);
      n_bad++;
    end
    wait_result("restart");
  endtask

  task automatic test_both_high();
    int seen;
    seen = 0;
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((busy !== 1'b0) || (data_resultRDY !== 1'b0)) seen++;
      @(negedge clock);
    end
    n_vec++;
    if (seen != 0) begin
      $display("FAIL both_high_ignored: got %0d active cycles want 0", seen);
      n_bad++;
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    seen = 0;
    run_op(1'b0, 32'd5, 32'd5, "pre_reset");
    start_op(1'b0, 32'd7, 32'hFFFFFFFA);
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    n_vec++;
    if ((data_result !== 32'd0) || (data_exception !== 1'b0) || (data_resultRDY !== 1'b0) || (busy !== 1'b0)) begin
      $display("FAIL mid_reset_state: got %h/%b/%b/%b want 0/0/0/0", data_result, data_exception, data_resultRDY, busy);
      n_bad++;
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((busy !== 1'b0) || (data_resultRDY !== 1'b0)) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      $display("FAIL mid_reset_no_rdy: got %0d active cycles want 0", seen);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_back_to_back();
    test_both_high();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
